conv_mac: RTL and testbench
===========================

CONV_MAC -- requirements
Module: conv_mac

Interface
REQ-001 SHALL have parameter BW, default 8, meaning signed element width of activations and weights.
REQ-002 SHALL have parameter BIAS_BW, default BW*2, meaning signed bias width.
REQ-003 SHALL have parameter COLUMN_LEN, default 2, meaning elements per column vector.
REQ-004 SHALL have parameter NUM_FILTERS, default 8, meaning filters per window.
REQ-005 SHALL derive localparams FILTER_LEN=3, VECTOR_BW=COLUMN_LEN*BW, ACC_BW=2*BW+$clog2(FILTER_LEN*COLUMN_LEN)+1.
REQ-006 SHALL have ports clk_i in 1 (single clock) and rst_n_i in 1; reset is asynchronous and active-low.
REQ-007 SHALL have act0_i, act1_i, act2_i, each in VECTOR_BW, signed three-column input window, oldest first.
REQ-008 SHALL have act_valid_i in 1 and act_ready_o out 1, the window handshake.
REQ-009 SHALL have data0_i, data1_i, data2_i, each in VECTOR_BW, signed filter taps from parameter memory.
REQ-010 SHALL have bias_i in BIAS_BW, param_valid_i in 1, param_last_i in 1 and param_ready_o out 1, the parameter stream.
REQ-011 SHALL have data_o out ACC_BW (signed result), valid_o out 1, last_o out 1 and ready_i in 1, the result stream.
REQ-012 SHALL have err_o out 1, sticky filter-count mismatch flag.

Function
REQ-013 SHALL implement FSM IDLE -> RUN -> IDLE; IDLE: act_ready_o=1, param_ready_o=0; RUN: act_ready_o=0.
REQ-014 SHALL latch window into registers on act_valid_i&act_ready_o, enter RUN next cycle, clear filter counter.
REQ-015 SHALL drive param_ready_o = (state==RUN) & (!valid_o | ready_i); no combinational path from param_valid_i to param_ready_o.
REQ-016 SHALL compute per accepted param beat: sum over taps t=0..2 and elements e of act_t[e]*data_t[e], plus sign-extended bias_i, at full ACC_BW precision without overflow.
REQ-017 SHALL register result into data_o with valid_o=1 exactly 1 cycle after the param handshake (latency 1); last_o = registered param_last_i.
REQ-018 SHALL hold data_o/valid_o/last_o stable while valid_o&!ready_i; clear valid_o on ready_i when no new beat is accepted.
REQ-019 SHALL sustain one result per cycle when ready_i stays high.
REQ-020 SHALL increment a filter counter (width $clog2(NUM_FILTERS)) per accepted param beat, wrapping at NUM_FILTERS-1 -> 0.
REQ-021 SHALL return to IDLE the cycle after accepting a beat with param_last_i=1; act_ready_o may be high while final result awaits ready_i.
REQ-022 SHALL set err_o when param_last_i=1 is accepted with counter!=NUM_FILTERS-1, or counter wraps without last; err_o cleared only by reset.
REQ-023 SHALL ignore param_valid_i in IDLE and act_valid_i in RUN (no state change, no data consumed).

Reset
REQ-024 SHALL on rst_n_i=0 asynchronously force state IDLE, counter 0, window regs 0, data_o 0, valid_o 0, last_o 0, err_o 0.
REQ-025 SHALL discard any in-flight window/result on reset mid-RUN; first cycle after release act_ready_o=1, valid_o=0.

Configuration
REQ-026 SHALL honour macro CONV_MAC_RELU_EN: defined -> negative sums clamp to 0 before output register; undefined -> raw signed sum output.

Structure
REQ-027 SHALL place FILTER_LEN, the FSM state enum (IDLE, RUN) and ACC_BW derivation function in shared package conv_pkg.
REQ-028 SHALL implement the dot product in combinational sub-module conv_dot3 (three vectors x three vectors + bias -> ACC_BW).

Verification
REQ-029 SHALL cover: all act elements=1, all taps=2, bias=5, ready_i=1 -> data_o=17 one cycle after handshake, 8 results, last_o on 8th.
REQ-030 SHALL cover: act elements=-128, taps=127, bias=-32768 -> data_o=-130304 without overflow (RELU undefined); 0 with CONV_MAC_RELU_EN.
REQ-031 SHALL cover: ready_i=0 for 5 cycles mid-stream -> param_ready_o=0, data_o/valid_o held, no beat lost or duplicated.
REQ-032 SHALL cover: param_last_i=1 on 3rd beat with NUM_FILTERS=8 -> err_o=1 next cycle, FSM returns IDLE, err_o sticky.
REQ-033 SHALL cover: rst_n_i asserted after 4th beat -> valid_o=0 immediately, act_ready_o=1 after release, next window processed correctly.
REQ-034 SHALL cover: act_valid_i pulsed during RUN -> ignored, window regs unchanged, results match original window.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared definitions for the convolution MAC: tap count, FSM states and accumulator sizing.
package conv_pkg;

   localparam int FILTER_LEN = 3;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      RUN  = 1'b1
   } convState_e;

   // Two full-width products plus enough guard bits to sum every tap and the bias.
   function automatic int accBw(input int bw, input int filterLen, input int columnLen);
      return 2 * bw + $clog2(filterLen * columnLen) + 1;
   endfunction

endpackage

// File: rtl/conv_dot3.sv
// Combinational three-column dot product: sum of act_t[e]*data_t[e] plus sign-extended bias.
module conv_dot3 import conv_pkg::*; #(
   parameter int BW         = 8,
   parameter int BIAS_BW    = 16,
   parameter int COLUMN_LEN = 2,
   parameter int ACC_BW     = accBw(BW, FILTER_LEN, COLUMN_LEN),
   localparam int VECTOR_BW = COLUMN_LEN * BW
) (
   input  logic signed [VECTOR_BW-1:0] act0_i,
   input  logic signed [VECTOR_BW-1:0] act1_i,
   input  logic signed [VECTOR_BW-1:0] act2_i,
   input  logic signed [VECTOR_BW-1:0] data0_i,
   input  logic signed [VECTOR_BW-1:0] data1_i,
   input  logic signed [VECTOR_BW-1:0] data2_i,
   input  logic signed [BIAS_BW-1:0]   bias_i,
   output logic signed [ACC_BW-1:0]    sum_o
);

   logic [VECTOR_BW-1:0]    actVec [FILTER_LEN];
   logic [VECTOR_BW-1:0]    tapVec [FILTER_LEN];
   logic signed [BW-1:0]    actElem;
   logic signed [BW-1:0]    tapElem;
   logic signed [2*BW-1:0]  prod;
   logic signed [ACC_BW-1:0] acc;

   assign actVec[0] = act0_i;
   assign actVec[1] = act1_i;
   assign actVec[2] = act2_i;
   assign tapVec[0] = data0_i;
   assign tapVec[1] = data1_i;
   assign tapVec[2] = data2_i;

   // Operands are widened before multiplying so no product or partial sum can wrap.
   always_comb begin
      acc     = ACC_BW'(bias_i);
      actElem = '0;
      tapElem = '0;
      prod    = '0;
      for (int t = 0; t < FILTER_LEN; t++) begin
         for (int e = 0; e < COLUMN_LEN; e++) begin
            actElem = actVec[t][e*BW +: BW];
            tapElem = tapVec[t][e*BW +: BW];
            prod    = (2*BW)'(actElem) * (2*BW)'(tapElem);
            acc     = acc + ACC_BW'(prod);
         end
      end
   end

   assign sum_o = acc;

endmodule

// File: rtl/conv_mac.sv
// Convolution MAC: latches a 3-column window, then emits one dot product per parameter beat.
// Optional CONV_MAC_RELU_EN clamps negative sums to zero before the output register.
module conv_mac import conv_pkg::*; #(
   parameter int BW          = 8,
   parameter int BIAS_BW     = BW * 2,
   parameter int COLUMN_LEN  = 2,
   parameter int NUM_FILTERS = 8,
   localparam int VECTOR_BW  = COLUMN_LEN * BW,
   localparam int ACC_BW     = accBw(BW, FILTER_LEN, COLUMN_LEN)
) (
   input  logic                        clk_i,
   input  logic                        rst_n_i,
   input  logic signed [VECTOR_BW-1:0] act0_i,
   input  logic signed [VECTOR_BW-1:0] act1_i,
   input  logic signed [VECTOR_BW-1:0] act2_i,
   input  logic                        act_valid_i,
   output logic                        act_ready_o,
   input  logic signed [VECTOR_BW-1:0] data0_i,
   input  logic signed [VECTOR_BW-1:0] data1_i,
   input  logic signed [VECTOR_BW-1:0] data2_i,
   input  logic signed [BIAS_BW-1:0]   bias_i,
   input  logic                        param_valid_i,
   input  logic                        param_last_i,
   output logic                        param_ready_o,
   output logic signed [ACC_BW-1:0]    data_o,
   output logic                        valid_o,
   output logic                        last_o,
   input  logic                        ready_i,
   output logic                        err_o
);

   localparam int              CNT_W   = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(NUM_FILTERS - 1);

   convState_e                  state_q, state_d;
   logic [CNT_W-1:0]            filterCnt_q, filterCnt_d;
   logic                        err_q, err_d;
   logic signed [VECTOR_BW-1:0] act0_q, act1_q, act2_q;
   logic signed [ACC_BW-1:0]    data_q;
   logic                        valid_q, last_q;
   logic signed [ACC_BW-1:0]    sum, result;
   logic                        actFire, paramFire, cntAtMax;

   assign act_ready_o   = (state_q == IDLE);
   assign param_ready_o = (state_q == RUN) & (!valid_q | ready_i);
   assign actFire       = act_valid_i & act_ready_o;
   assign paramFire     = param_valid_i & param_ready_o;
   assign cntAtMax      = (filterCnt_q == CNT_MAX);

   conv_dot3 #(
      .BW         (BW),
      .BIAS_BW    (BIAS_BW),
      .COLUMN_LEN (COLUMN_LEN),
      .ACC_BW     (ACC_BW)
   ) u_dot3 (
      .act0_i  (act0_q),
      .act1_i  (act1_q),
      .act2_i  (act2_q),
      .data0_i (data0_i),
      .data1_i (data1_i),
      .data2_i (data2_i),
      .bias_i  (bias_i),
      .sum_o   (sum)
   );

`ifdef CONV_MAC_RELU_EN
   assign result = sum[ACC_BW-1] ? '0 : sum;
`else
   assign result = sum;
`endif

   // A last beat off the final filter index, or a wrap without last, is a framing error.
   always_comb begin
      state_d     = state_q;
      filterCnt_d = filterCnt_q;
      err_d       = err_q;
      if (actFire) begin
         state_d     = RUN;
         filterCnt_d = '0;
      end else if (paramFire) begin
         filterCnt_d = cntAtMax ? '0 : filterCnt_q + CNT_W'(1);
         if (param_last_i) begin
            state_d = IDLE;
         end
         if (param_last_i != cntAtMax) begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q     <= IDLE;
         filterCnt_q <= '0;
         err_q       <= 1'b0;
         act0_q      <= '0;
         act1_q      <= '0;
         act2_q      <= '0;
      end else begin
         state_q     <= state_d;
         filterCnt_q <= filterCnt_d;
         err_q       <= err_d;
         if (actFire) begin
            act0_q <= act0_i;
            act1_q <= act1_i;
            act2_q <= act2_i;
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
      end else if (paramFire) begin
         data_q  <= result;
         valid_q <= 1'b1;
         last_q  <= param_last_i;
      end else if (ready_i) begin
         valid_q <= 1'b0;
      end
   end

   assign data_o  = data_q;
   assign valid_o = valid_q;
   assign last_o  = last_q;
   assign err_o   = err_q;

endmodule

// File: tb/tb_conv_mac.sv
// Directed bench for conv_mac with hand-computed dot products; honours CONV_MAC_RELU_EN.
module tb_conv_mac;

   localparam int BW        = 8;
   localparam int VECTOR_BW = 16;
   localparam int BIAS_BW   = 16;
   localparam int ACC_BW    = 20;
`ifdef CONV_MAC_RELU_EN
   localparam int EXP_WIDE  = 0;
`else
   localparam int EXP_WIDE  = -130304;
`endif

   logic                        clk_i;
   logic                        rst_n_i;
   logic signed [VECTOR_BW-1:0] act0_i, act1_i, act2_i;
   logic                        act_valid_i;
   logic                        act_ready_o;
   logic signed [VECTOR_BW-1:0] data0_i, data1_i, data2_i;
   logic signed [BIAS_BW-1:0]   bias_i;
   logic                        param_valid_i;
   logic                        param_last_i;
   logic                        param_ready_o;
   logic signed [ACC_BW-1:0]    data_o;
   logic                        valid_o;
   logic                        last_o;
   logic                        ready_i;
   logic                        err_o;

   int checks = 0;
   int errors = 0;

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   conv_mac dut (
      .clk_i         (clk_i),
      .rst_n_i       (rst_n_i),
      .act0_i        (act0_i),
      .act1_i        (act1_i),
      .act2_i        (act2_i),
      .act_valid_i   (act_valid_i),
      .act_ready_o   (act_ready_o),
      .data0_i       (data0_i),
      .data1_i       (data1_i),
      .data2_i       (data2_i),
      .bias_i        (bias_i),
      .param_valid_i (param_valid_i),
      .param_last_i  (param_last_i),
      .param_ready_o (param_ready_o),
      .data_o        (data_o),
      .valid_o       (valid_o),
      .last_o        (last_o),
      .ready_i       (ready_i),
      .err_o         (err_o)
   );

   function automatic logic [VECTOR_BW-1:0] fill(input logic signed [BW-1:0] v);
      return {v, v};
   endfunction

   task automatic checkOutput(input string tag, input logic signed [31:0] observed,
                              input logic signed [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   task automatic checkResult(input string tag, input int expData, input logic expLast);
      checkOutput({tag, "_valid"}, valid_o, 1);
      checkOutput({tag, "_data"}, data_o, expData);
      checkOutput({tag, "_last"}, last_o, expLast);
   endtask

   // Presents a window while IDLE and leaves the bench at the negedge after acceptance.
   task automatic applyWindow(input logic signed [BW-1:0] a);
      act0_i      = fill(a);
      act1_i      = fill(a);
      act2_i      = fill(a);
      act_valid_i = 1'b1;
      #1 checkOutput("actReadyIdle", act_ready_o, 1);
      @(negedge clk_i);
      act_valid_i = 1'b0;
      checkOutput("actReadyRun", act_ready_o, 0);
   endtask

   task automatic applyStimulus(input logic signed [BW-1:0] tap,
                                input logic signed [BIAS_BW-1:0] bias, input logic last);
      data0_i       = fill(tap);
      data1_i       = fill(tap);
      data2_i       = fill(tap);
      bias_i        = bias;
      param_last_i  = last;
      param_valid_i = 1'b1;
   endtask

   task automatic endParams();
      param_valid_i = 1'b0;
      param_last_i  = 1'b0;
   endtask

   initial begin
      rst_n_i = 1'b0;
      act0_i = '0; act1_i = '0; act2_i = '0; act_valid_i = 1'b0;
      data0_i = '0; data1_i = '0; data2_i = '0; bias_i = '0;
      param_valid_i = 1'b0; param_last_i = 1'b0; ready_i = 1'b1;

      repeat (2) @(negedge clk_i);
      checkOutput("rstActReady", act_ready_o, 1);
      checkOutput("rstParamReady", param_ready_o, 0);
      checkOutput("rstValid", valid_o, 0);
      checkOutput("rstData", data_o, 0);
      checkOutput("rstLast", last_o, 0);
      checkOutput("rstErr", err_o, 0);
      rst_n_i = 1'b1;
      @(negedge clk_i);

      // Ones window, taps of two, bias five: 6*1*2+5 = 17 on every beat.
      applyWindow(8'sd1);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'sd2, 16'sd5, k == 7);
         @(negedge clk_i);
         checkResult("dotOnes", 17, k == 7);
      end
      endParams();
      checkOutput("idleAfterLast", act_ready_o, 1);
      checkOutput("noErrOnes", err_o, 0);
      @(negedge clk_i);
      checkOutput("validCleared", valid_o, 0);

      // Parameter beats offered while IDLE must be ignored.
      applyStimulus(8'sd9, 16'sd9, 1'b1);
      #1 checkOutput("idleParamReady", param_ready_o, 0);
      @(negedge clk_i);
      checkOutput("idleNoResult", valid_o, 0);
      checkOutput("idleStays", act_ready_o, 1);
      endParams();

      // Extreme operands: 6*(-128*127) - 32768 = -130304 fits the accumulator.
      applyWindow(-8'sd128);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'sd127, -16'sd32768, k == 7);
         @(negedge clk_i);
         checkResult("dotWide", EXP_WIDE, k == 7);
      end
      endParams();
      @(negedge clk_i);

      // Backpressure: ready_i low for five cycles with beat 2 pending; tap k+1 gives 18*(k+1).
      applyWindow(8'sd3);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(BW'(k + 1), 16'sd0, k == 7);
         if (k == 2) begin
            ready_i = 1'b0;
            repeat (5) begin
               #1 checkOutput("stallParamReady", param_ready_o, 0);
               @(negedge clk_i);
               checkResult("stallHold", 36, 1'b0);
            end
            ready_i = 1'b1;
            #1 checkOutput("resumeParamReady", param_ready_o, 1);
         end
         @(negedge clk_i);
         checkResult("stallStream", 18 * (k + 1), k == 7);
      end
      endParams();
      checkOutput("stallNoErr", err_o, 0);
      @(negedge clk_i);

      // Early last on the third beat: framing error, return to IDLE.
      applyWindow(8'sd1);
      for (int k = 0; k < 3; k++) begin
         applyStimulus(8'sd1, 16'sd0, k == 2);
         @(negedge clk_i);
         checkResult("errStream", 6, k == 2);
         if (k < 2) checkOutput("errNotYet", err_o, 0);
      end
      endParams();
      checkOutput("errSet", err_o, 1);
      checkOutput("errIdle", act_ready_o, 1);
      @(negedge clk_i);
      checkOutput("errHeld", err_o, 1);

      // A window offered mid-RUN must not disturb the latched one (2*1*6 = 12).
      applyWindow(8'sd2);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'sd1, 16'sd0, k == 7);
         if (k == 3) begin
            act0_i = fill(8'sd50);
            act1_i = fill(8'sd50);
            act2_i = fill(8'sd50);
            act_valid_i = 1'b1;
         end
         @(negedge clk_i);
         act_valid_i = 1'b0;
         checkResult("actIgnored", 12, k == 7);
      end
      endParams();
      checkOutput("errSticky", err_o, 1);
      @(negedge clk_i);

      // Reset after the fourth beat discards everything; the next window runs cleanly.
      applyWindow(8'sd1);
      for (int k = 0; k < 4; k++) begin
         applyStimulus(8'sd2, 16'sd5, 1'b0);
         @(negedge clk_i);
         checkResult("preReset", 17, 1'b0);
      end
      rst_n_i = 1'b0;
      #1;
      checkOutput("rstMidValid", valid_o, 0);
      checkOutput("rstMidData", data_o, 0);
      checkOutput("rstMidErr", err_o, 0);
      endParams();
      @(negedge clk_i);
      rst_n_i = 1'b1;
      #1;
      checkOutput("relActReady", act_ready_o, 1);
      checkOutput("relValid", valid_o, 0);
      applyWindow(-8'sd1);
      for (int k = 0; k < 8; k++) begin
         applyStimulus(8'sd3, 16'sd100, k == 7);
         @(negedge clk_i);
         checkResult("postReset", 82, k == 7);
      end
      endParams();
      checkOutput("postResetErr", err_o, 0);
      @(negedge clk_i);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
